lpc_record_buffer: RTL and testbench

Buffers decoded LPC cycles and serializes them into a byte stream. It sits directly downstream of the LPC cycle decoder: it detects each rising edge of the decoder's latch strobe, packs cycle type/direction, 16-bit address and data byte into a 4-byte record, and queues it in a record FIFO. A valid/ready byte port drains the FIFO toward the host transport (UART/USB bridge). Loss is reported through a sequence field, an overflow flag and a drop counter.

---
 rtl/lpc_record_buffer_if.sv | 34 +++
 rtl/lpc_record_buffer.sv | 175 +++++++++++++++++
 tb/tb_lpc_record_buffer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/lpc_record_buffer_if.sv
// ============================================================================
// lpc_record_buffer_if : decoder-side cycle bus plus serialized byte stream
// Revision 1.0
// ============================================================================
`default_nettype none

interface lpc_record_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [3:0]       in_cyctype_dir;
  logic [31:0]      in_addr;
  logic [7:0]       in_data;
  logic             in_latch;
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       drop_count;

  modport master (
    output in_cyctype_dir, in_addr, in_data, in_latch, out_ready,
    input  out_byte, out_valid, out_sof, fifo_level, drop_count
  );

  modport slave (
    input  in_cyctype_dir, in_addr, in_data, in_latch, out_ready,
    output out_byte, out_valid, out_sof, fifo_level, drop_count
  );
endinterface

`default_nettype wire

// File: rtl/lpc_record_buffer.sv
// ============================================================================
// lpc_record_buffer : packs decoded LPC cycles into 4-byte records, queues
// them and streams them out one byte at a time over valid/ready.
// Revision 1.0
// ============================================================================
`default_nettype none

module lpc_record_buffer #(
  parameter int DEPTH = 8
) (
  input  wire logic         lpc_clock,
  input  wire logic         lpc_reset,
  lpc_record_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               latch_q, latch_d;
  logic [2:0]         seq_q, seq_d;
  logic               ovf_pending_q, ovf_pending_d;
  logic [7:0]         drop_count_q, drop_count_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   level_q, level_d;
  logic [1:0]         idx_q, idx_d;
  logic [23:0]        shift_q, shift_d;
  logic [7:0]         out_byte_q, out_byte_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sof_q, out_sof_d;

  logic [31:0]        mem_q [DEPTH];
  logic               evt;
  logic               full;
  logic               wr_en;
  logic               pop;
  logic [31:0]        rec_word;
  logic [31:0]        head;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^bus.in_addr[31:16];

  always_comb begin
    evt      = bus.in_latch & ~latch_q;
    full     = (level_q == CNT_W'(DEPTH));
    wr_en    = evt & ~full;
    rec_word = {bus.in_cyctype_dir, ovf_pending_q, seq_q,
                bus.in_addr[15:0], bus.in_data};
    head     = mem_q[rd_cnt_q[PTR_W-1:0]];

    latch_d       = bus.in_latch;
    seq_d         = seq_q;
    ovf_pending_d = ovf_pending_q;
    drop_count_d  = drop_count_q;
    wr_cnt_d      = wr_cnt_q;

    if (evt) begin
      seq_d = seq_q + 3'd1;
      if (full) begin
        // A pop on this same edge does not rescue the record.
        ovf_pending_d = 1'b1;
        if (drop_count_q != 8'hFF) begin
          drop_count_d = drop_count_q + 8'd1;
        end
      end else begin
        ovf_pending_d = 1'b0;
        wr_cnt_d      = wr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    rd_cnt_d    = rd_cnt_q;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          pop = 1'b1;
        end
      end
      ST_SEND: begin
        if (out_valid_q && bus.out_ready) begin
          if (idx_q == 2'd3) begin
            // Chain straight into the next record so the stream has no bubble.
            if (level_q != '0) begin
              pop = 1'b1;
            end else begin
              out_valid_d = 1'b0;
              out_sof_d   = 1'b0;
              state_d     = ST_IDLE;
            end
          end else begin
            idx_d      = idx_q + 2'd1;
            out_byte_d = shift_q[23:16];
            shift_d    = {shift_q[15:0], 8'h00};
            out_sof_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop) begin
      rd_cnt_d    = rd_cnt_q + CNT_W'(1);
      out_byte_d  = head[31:24];
      shift_d     = head[23:0];
      idx_d       = 2'd0;
      out_valid_d = 1'b1;
      out_sof_d   = 1'b1;
      state_d     = ST_SEND;
    end

    level_d = wr_cnt_d - rd_cnt_d;
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q       <= ST_IDLE;
      latch_q       <= 1'b0;
      seq_q         <= 3'd0;
      ovf_pending_q <= 1'b0;
      drop_count_q  <= 8'd0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      level_q       <= '0;
      idx_q         <= 2'd0;
      shift_q       <= 24'd0;
      out_byte_q    <= 8'd0;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      latch_q       <= latch_d;
      seq_q         <= seq_d;
      ovf_pending_q <= ovf_pending_d;
      drop_count_q  <= drop_count_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      level_q       <= level_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      out_byte_q    <= out_byte_d;
      out_valid_q   <= out_valid_d;
      out_sof_q     <= out_sof_d;
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (wr_en) begin
      mem_q[wr_cnt_q[PTR_W-1:0]] <= rec_word;
    end
  end

  assign bus.out_byte   = out_byte_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sof    = out_sof_q;
  assign bus.fifo_level = level_q;
  assign bus.drop_count = drop_count_q;
endmodule

`default_nettype wire

// File: tb/tb_lpc_record_buffer.sv
// ============================================================================
// tb_lpc_record_buffer : directed stimulus, queued expected bytes, and an
// independent stream monitor that pops and compares on every handshake.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lpc_record_buffer;
  localparam int DEPTH = 8;

  logic lpc_clock = 1'b0;
  logic lpc_reset = 1'b0;
  always #5 lpc_clock = ~lpc_clock;

  lpc_record_buffer_if #(.DEPTH(DEPTH)) bus ();

  lpc_record_buffer #(.DEPTH(DEPTH)) dut (
    .lpc_clock (lpc_clock),
    .lpc_reset (lpc_reset),
    .bus       (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [2:0] m_seq;
  logic       m_ovf;
  logic [7:0] last_b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream monitor: a byte is transferred at the next rising edge.
  always @(negedge lpc_clock) begin
    if (lpc_reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL stream_extra: got byte 0x%0h, expected no byte", bus.out_byte);
      end else begin
        mon_e = exp_q.pop_front();
        check("stream_byte", 32'(bus.out_byte), 32'(mon_e[7:0]));
        check("stream_sof", 32'(bus.out_sof), 32'(mon_e[8]));
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) @(posedge lpc_clock);
    #1;
  endtask

  // Raise the latch (held for 'hold' edges) and queue the expected record.
  task automatic fire(input logic [3:0] ct, input logic [15:0] a, input logic [7:0] d,
                      input bit drop, input int hold);
    logic [7:0] b0;
    bus.in_cyctype_dir = ct;
    bus.in_addr        = {16'hDEAD, a};
    bus.in_data        = d;
    bus.in_latch       = 1'b1;
    b0 = {ct, m_ovf, m_seq};
    if (!drop) begin
      exp_q.push_back({1'b1, b0});
      exp_q.push_back({1'b0, a[15:8]});
      exp_q.push_back({1'b0, a[7:0]});
      exp_q.push_back({1'b0, d});
      m_ovf   = 1'b0;
      last_b0 = b0;
    end else begin
      m_ovf = 1'b1;
    end
    m_seq = m_seq + 3'd1;
    repeat (hold) @(posedge lpc_clock);
    #1;
    bus.in_latch = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      @(posedge lpc_clock);
      #1;
      n++;
    end
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_cyctype_dir = 4'h0;
    bus.in_addr        = 32'h0;
    bus.in_data        = 8'h0;
    bus.in_latch       = 1'b0;
    bus.out_ready      = 1'b0;
    m_seq   = 3'd0;
    m_ovf   = 1'b0;
    last_b0 = 8'h0;

    // Reset values
    gap(3);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_byte", 32'(bus.out_byte), 32'd0);
    check("rst_sof", 32'(bus.out_sof), 32'd0);
    check("rst_level", 32'(bus.fifo_level), 32'd0);
    check("rst_drop", 32'(bus.drop_count), 32'd0);
    @(negedge lpc_clock);
    lpc_reset = 1'b1;
    gap(2);

    // Single cycle: 0x20 0x00 0x80 0x5A, two-edge latency
    bus.out_ready = 1'b1;
    fire(4'h2, 16'h0080, 8'h5A, 1'b0, 1);
    check("single_lat_e0", 32'(bus.out_valid), 32'd0);
    check("single_level_e0", 32'(bus.fifo_level), 32'd1);
    gap(1);
    check("single_lat_e1", 32'(bus.out_valid), 32'd1);
    check("single_b0", 32'(bus.out_byte), 32'h20);
    check("single_level_e1", 32'(bus.fifo_level), 32'd0);
    gap(4);
    check("single_done", 32'(bus.out_valid), 32'd0);
    drain("single");

    // Back-pressure: byte 0 held for 20 cycles
    bus.out_ready = 1'b0;
    gap(8);
    fire(4'h2, 16'h0080, 8'h5A, 1'b0, 1);
    gap(1);
    for (int i = 0; i < 20; i++) begin
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_byte", 32'(bus.out_byte), 32'(last_b0));
      gap(1);
    end
    bus.out_ready = 1'b1;
    drain("bp");

    // Back-to-back: three queued records, 12 consecutive valid cycles
    bus.out_ready = 1'b0;
    fire(4'h3, 16'hA1B2, 8'h11, 1'b0, 1);
    gap(10);
    fire(4'h1, 16'hC3D4, 8'h22, 1'b0, 1);
    gap(10);
    fire(4'hA, 16'hE5F6, 8'h33, 1'b0, 1);
    gap(2);
    check("b2b_level", 32'(bus.fifo_level), 32'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge lpc_clock);
      check("b2b_valid", 32'(bus.out_valid), 32'd1);
      check("b2b_sof", 32'(bus.out_sof), ((i % 4) == 0) ? 32'd1 : 32'd0);
    end
    @(negedge lpc_clock);
    check("b2b_end", 32'(bus.out_valid), 32'd0);
    gap(1);
    drain("b2b");

    // Held latch: one record, then a toggle gives a second with seq+1
    fire(4'h6, 16'h1234, 8'hC3, 1'b0, 30);
    gap(10);
    fire(4'h6, 16'h5678, 8'h3C, 1'b0, 1);
    drain("held");
    check("held_drop", 32'(bus.drop_count), 32'd0);

    // Reset mid-record after byte 1 with two records still queued
    bus.out_ready = 1'b0;
    fire(4'h7, 16'h0101, 8'h01, 1'b0, 1);
    gap(10);
    fire(4'h7, 16'h0202, 8'h02, 1'b0, 1);
    gap(10);
    fire(4'h7, 16'h0303, 8'h03, 1'b0, 1);
    gap(3);
    bus.out_ready = 1'b1;
    gap(2);
    lpc_reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_byte", 32'(bus.out_byte), 32'd0);
    check("mid_rst_sof", 32'(bus.out_sof), 32'd0);
    check("mid_rst_level", 32'(bus.fifo_level), 32'd0);
    check("mid_rst_drop", 32'(bus.drop_count), 32'd0);
    exp_q.delete();
    m_seq = 3'd0;
    m_ovf = 1'b0;
    @(negedge lpc_clock);
    lpc_reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      gap(1);
      check("mid_rst_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Overflow: serializer holds event 0, FIFO holds events 1..8, 9..11 dropped
    bus.out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      fire(4'h5, 16'h1000 + 16'(k), 8'(k), (k >= 9), 1);
      gap(4);
    end
    check("ovf_level", 32'(bus.fifo_level), 32'd8);
    check("ovf_drop", 32'(bus.drop_count), 32'd3);
    check("ovf_head", 32'(bus.out_byte), 32'h50);
    bus.out_ready = 1'b1;
    drain("ovf_flush");
    fire(4'h5, 16'h100C, 8'h0C, 1'b0, 1);
    check("ovf_flag_b0", 32'(last_b0), 32'h5C);
    drain("ovf_flagged");
    fire(4'h5, 16'h100D, 8'h0D, 1'b0, 1);
    drain("ovf_cleared");
    check("ovf_drop_final", 32'(bus.drop_count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
